// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and limits for the memory port arbiter.
// Round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int NUM_CH_DEF    = 2;
    localparam int NUM_CH_MIN    = 1;
    localparam int NUM_CH_MAX    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Index width for a channel count (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational NUM_CH-way picker: first requester at or after i_start.
// A start of zero gives plain fixed priority (lowest index wins).
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    localparam int IW    = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IW-1:0]     i_start,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IW-1:0]     o_idx,
    output logic              o_any
);

    logic [NUM_CH-1:0] w_rot;

    // Rotate so i_start sits at bit 0, then take the lowest set bit.
    always_comb begin
        int s;
        s      = 0;
        o_any  = |i_req;
        o_idx  = '0;
        w_rot  = NUM_CH'({i_req, i_req} >> i_start);
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                s = k + int'(i_start);
                if (s >= NUM_CH) s = s - NUM_CH;
                o_idx = IW'(s);
            end
        end
        o_grant = o_any ? (NUM_CH'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared-bus memory controller: arbitrates client ports onto one bus.
// Define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NUM_CH    = NUM_CH_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           req_valid,
    input  logic [NUM_CH-1:0]           req_write,
    input  logic [NUM_CH*WORD_SIZE-1:0] req_addr,
    input  logic [NUM_CH*WORD_SIZE-1:0] req_wdata,
    output logic [NUM_CH-1:0]           req_accept,
    output logic [NUM_CH-1:0]           resp_valid,
    output logic [WORD_SIZE-1:0]        resp_rdata,
    output logic                        readM,
    output logic                        writeM,
    output logic [WORD_SIZE-1:0]        address,
    inout  wire  [WORD_SIZE-1:0]        data,
    input  logic                        inputReady,
    input  logic                        ackOutput
);

    localparam int IW = idx_w(NUM_CH);

    state_t                r_state;
    logic [NUM_CH-1:0]     r_own;
    logic [WORD_SIZE-1:0]  r_addr;
    logic [WORD_SIZE-1:0]  r_wdata;
    logic [WORD_SIZE-1:0]  r_rdata;
    logic                  r_readM;
    logic                  r_writeM;
    logic [NUM_CH-1:0]     r_resp;

    logic [NUM_CH-1:0]     w_grant;
    logic [IW-1:0]         w_idx;
    logic                  w_any;
    logic [IW-1:0]         w_start;
    logic                  w_wr;
    logic [WORD_SIZE-1:0]  w_addr;
    logic [WORD_SIZE-1:0]  w_wdata;
    logic                  w_take;

    mem_arb_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .i_req   (req_valid),
        .i_start (w_start),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_take = (r_state == ST_IDLE) && w_any;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] r_rr;

    // Move the search start just past each accepted winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr <= '0;
        end else if (w_take) begin
            r_rr <= (w_idx == IW'(NUM_CH - 1)) ? '0 : w_idx + IW'(1);
        end
    end

    assign w_start = r_rr;
`else
    assign w_start = '0;
`endif

    // Select the winning channel's request fields.
    always_comb begin
        w_wr    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_idx == IW'(i)) begin
                w_wr    = req_write[i];
                w_addr  = req_addr[i*WORD_SIZE +: WORD_SIZE];
                w_wdata = req_wdata[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Bus transaction sequencer with registered strobes and response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_own    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_readM  <= 1'b0;
            r_writeM <= 1'b0;
            r_resp   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_own    <= w_grant;
                        r_addr   <= w_addr;
                        r_wdata  <= w_wdata;
                        r_readM  <= ~w_wr;
                        r_writeM <= w_wr;
                        r_state  <= w_wr ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (inputReady) begin
                        r_rdata <= data;
                        r_readM <= 1'b0;
                        r_resp  <= r_own;
                        r_state <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    if (ackOutput) begin
                        r_writeM <= 1'b0;
                        r_resp   <= r_own;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_resp  <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_accept = w_take ? w_grant : '0;
    assign resp_valid = r_resp;
    assign resp_rdata = r_rdata;
    assign readM      = r_readM;
    assign writeM     = r_writeM;
    assign address    = r_addr;
    assign data       = r_writeM ? r_wdata : {WORD_SIZE{1'bz}};

endmodule
